// File: rtl/seq_dot2_pkg.sv
// seq_dot2_pkg: shared widths, FSM state type and iteration helpers for seq_dot2_mac.
//   W       operand width (16)
//   OW      result width (34, top bits zero)
//   state_t IDLE / RUN / DONE
//   n_iter  iterations needed to retire a W-bit multiplier STEP bits at a time
//   cnt_w   width of the iteration counter for a given STEP
package seq_dot2_pkg;

   localparam int W  = 16;
   localparam int OW = 34;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   function automatic int n_iter(input int step);
      return W / step;
   endfunction

   function automatic int cnt_w(input int step);
      return $clog2(W / step + 1);
   endfunction

endpackage

// File: rtl/seq_dot2_mac_dot2_step.sv
// dot2_step: combinational slice a0*b0 + a1*b1 for one STEP-bit multiplier digit.
//   a0, a1  16-bit multiplicands
//   b0, b1  STEP-bit multiplier digits
//   sum     a0*b0 + a1*b1, W+STEP+1 bits (cannot overflow)
module dot2_step
   import seq_dot2_pkg::*;
#(
   parameter int STEP = 2
) (
   input  logic [W-1:0]    a0,
   input  logic [W-1:0]    a1,
   input  logic [STEP-1:0] b0,
   input  logic [STEP-1:0] b1,
   output logic [W+STEP:0] sum
);

   localparam int PW = W + STEP + 1;

   assign sum = PW'(a0) * PW'(b0) + PW'(a1) * PW'(b1);

endmodule

// File: rtl/seq_dot2_mac.sv
// seq_dot2_mac: multi-cycle shift-add engine computing out1 = in1*in2 + in3*in4.
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid / in_ready  operand handshake; in1..in4 sampled only on acceptance
//   in1, in3             multiplicands; in2, in4 multipliers (16-bit unsigned)
//   out_valid/out_ready  result handshake; out1 held while out_valid && !out_ready
//   out1                 34-bit zero-extended result
//   busy                 high while iterating
module seq_dot2_mac #(
   parameter int STEP = 2,
   parameter int W    = 16,
   parameter int OW   = 34
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [W-1:0]  in1,
   input  logic [W-1:0]  in2,
   input  logic [W-1:0]  in3,
   input  logic [W-1:0]  in4,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [OW-1:0] out1,
   output logic          busy
);

   import seq_dot2_pkg::*;

   localparam int N  = n_iter(STEP);
   localparam int CW = cnt_w(STEP);
   localparam int AW = 2 * W + 1;
   localparam int PW = W + STEP + 1;

   if (!(STEP == 1 || STEP == 2 || STEP == 4 || STEP == 8 || STEP == 16)) begin : g_bad_step
      $error("seq_dot2_mac: STEP must be 1, 2, 4, 8 or 16");
   end
   if (W != 16) begin : g_bad_w
      $error("seq_dot2_mac: W must be 16");
   end
   if (OW < 2 * W + 1) begin : g_bad_ow
      $error("seq_dot2_mac: OW must be at least 2*W+1");
   end

   state_t         state, state_nx;
   logic [W-1:0]   in1_r, in2_r, in3_r, in4_r;
   logic [CW-1:0]  cnt;
   logic [AW-1:0]  acc, acc_nx;
   logic [PW-1:0]  term;
   logic [5:0]     sh;
   logic           last;
   logic           take;

   dot2_step #(.STEP(STEP)) u_step (
      .a0  (in1_r),
      .a1  (in3_r),
      .b0  (in2_r[STEP-1:0]),
      .b1  (in4_r[STEP-1:0]),
      .sum (term)
   );

   // The low multiplier digits are consumed first, so digit cnt weighs 2^(cnt*STEP).
   assign sh     = 6'(cnt) * 6'(STEP);
   assign acc_nx = acc + (AW'(term) << sh);
   assign last   = cnt == CW'(N - 1);
   assign take   = in_valid && in_ready;

   always_comb begin
      state_nx  = state;
      in_ready  = state == IDLE;
      busy      = state == RUN;
      out_valid = state == DONE;
      case (state)
         IDLE:    state_nx = in_valid  ? RUN  : IDLE;
         RUN:     state_nx = last      ? DONE : RUN;
         DONE:    state_nx = out_ready ? IDLE : DONE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
         acc   <= '0;
         in1_r <= '0;
         in2_r <= '0;
         in3_r <= '0;
         in4_r <= '0;
         out1  <= '0;
      end else begin
         state <= state_nx;
         if (take) begin
            in1_r <= in1;
            in2_r <= in2;
            in3_r <= in3;
            in4_r <= in4;
            acc   <= '0;
            cnt   <= '0;
         end else if (state == RUN) begin
            acc   <= acc_nx;
            in2_r <= in2_r >> STEP;
            in4_r <= in4_r >> STEP;
            cnt   <= cnt + CW'(1);
            if (last)
               out1 <= OW'(acc_nx);
         end
      end
   end

endmodule

// File: tb/tb_seq_dot2_mac.sv
// tb_seq_dot2_mac: self-checking bench for seq_dot2_mac, one instance per legal STEP.
module tb_seq_dot2_mac;

   localparam int NS = 5;
   localparam int M  = 1;

   logic          clk = 1'b0;
   logic          rst_n, in_valid, out_ready, b2b;
   logic [15:0]   in1, in2, in3, in4;
   logic [NS-1:0] in_ready, out_valid, busy;
   logic [33:0]   out1 [NS];
   int            tests = 0;
   int            fails = 0;
   int            cyc   = 0;

   typedef struct {
      logic [15:0] a, b, c, d;
      logic [33:0] r;
   } vec_t;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, want %0h", nm, act, exp);
      end
   endfunction

   for (genvar g = 0; g < NS; g++) begin : g_dut
      localparam int N = 16 >> g;
      logic [33:0] exp_q[$];
      int          acc_q[$];
      int          prev    = 0;
      bit          prev_ok = 0;
      bit          seen    = 0;

      seq_dot2_mac #(.STEP(1 << g)) dut (
         .clk       (clk),
         .rst_n     (rst_n),
         .in_valid  (in_valid),
         .in_ready  (in_ready[g]),
         .in1       (in1),
         .in2       (in2),
         .in3       (in3),
         .in4       (in4),
         .out_valid (out_valid[g]),
         .out_ready (out_ready),
         .out1      (out1[g]),
         .busy      (busy[g])
      );

      always @(negedge clk) begin
         if (!rst_n) begin
            exp_q.delete();
            acc_q.delete();
            prev_ok = 0;
            seen    = 0;
         end else begin
            if (out_valid[g] && !seen) begin
               seen = 1;
               chk($sformatf("s%0d_pending", 1 << g), 64'(exp_q.size() > 0), 1);
               if (acc_q.size() > 0)
                  chk($sformatf("s%0d_latency", 1 << g), 64'(cyc - acc_q[0]), 64'(N + 1));
            end
            if (out_valid[g] && out_ready) begin
               seen = 0;
               if (exp_q.size() > 0) begin
                  chk($sformatf("s%0d_out1", 1 << g), out1[g], exp_q.pop_front());
                  void'(acc_q.pop_front());
               end
            end
            if (in_valid && in_ready[g]) begin
               exp_q.push_back(34'(in1) * 34'(in2) + 34'(in3) * 34'(in4));
               acc_q.push_back(cyc);
               if (b2b && prev_ok)
                  chk($sformatf("s%0d_spacing", 1 << g), 64'(cyc - prev), 64'(N + 2));
               prev    = cyc;
               prev_ok = b2b;
            end
         end
      end
   end

   task automatic rnd();
      in1 = 16'($urandom);
      in2 = 16'($urandom);
      in3 = 16'($urandom);
      in4 = 16'($urandom);
   endtask

   task automatic send(input logic [15:0] a, b, c, d);
      bit got = 0;
      in1 = a;
      in2 = b;
      in3 = c;
      in4 = d;
      in_valid = 1'b1;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (in_ready[M]) begin
            got = 1;
            break;
         end
      end
      chk("send_accept", 64'(got), 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      rnd();
   endtask

   task automatic wait_out();
      bit got = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (out_valid[M]) begin
            got = 1;
            break;
         end
      end
      chk("out_timeout", 64'(got), 1);
   endtask

   task automatic drain();
      out_ready = 1'b1;
      repeat (40) @(posedge clk);
      #1;
   endtask

   task automatic chk_reset(input int i, input string tag);
      chk($sformatf("%s_in_ready%0d", tag, i), in_ready[i], 1);
      chk($sformatf("%s_out_valid%0d", tag, i), out_valid[i], 0);
      chk($sformatf("%s_out1_%0d", tag, i), out1[i], 0);
      chk($sformatf("%s_busy%0d", tag, i), busy[i], 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vec_t        vt [8];
      logic [15:0] a, b, c, d;
      logic [33:0] e;
      int          nv;
      vt[0] = '{16'd3,      16'd5,      16'd7,      16'd11,     34'd92};
      vt[1] = '{16'hFFFF,   16'hFFFF,   16'hFFFF,   16'hFFFF,   34'h1_FFFC_0002};
      vt[2] = '{16'd0,      16'hFFFF,   16'h8000,   16'd2,      34'h0_0001_0000};
      vt[3] = '{16'd1,      16'd1,      16'd0,      16'd0,      34'd1};
      vt[4] = '{16'd1,      16'd0,      16'd0,      16'd1,      34'd0};
      vt[5] = '{16'h0100,   16'h0100,   16'd0,      16'd0,      34'h0_0001_0000};
      vt[6] = '{16'd2,      16'd3,      16'd4,      16'd5,      34'd26};
      vt[7] = '{16'hFFFF,   16'd1,      16'd1,      16'hFFFF,   34'h0_0001_FFFE};

      rst_n = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      b2b = 1'b0;
      {in1, in2, in3, in4} = '0;
      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < NS; i++) chk_reset(i, "por");
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < 8; i++) begin
         send(vt[i].a, vt[i].b, vt[i].c, vt[i].d);
         wait_out();
         chk($sformatf("vec%0d_out1", i), out1[M], vt[i].r);
         chk($sformatf("vec%0d_busy", i), busy[M], 0);
         chk($sformatf("vec%0d_in_ready", i), in_ready[M], 0);
         @(posedge clk);
         #1;
      end

      drain();
      out_ready = 1'b0;
      a = 16'($urandom);
      b = 16'($urandom);
      c = 16'($urandom);
      d = 16'($urandom);
      e = 34'(a) * 34'(b) + 34'(c) * 34'(d);
      send(a, b, c, d);
      wait_out();
      for (int k = 0; k < 20; k++) begin
         @(posedge clk);
         #1;
         in_valid = k[0];
         rnd();
         @(negedge clk);
         chk("bp_out1", out1[M], e);
         chk("bp_out_valid", out_valid[M], 1);
         chk("bp_in_ready", in_ready[M], 0);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      chk("hs_still_valid", out_valid[M], 1);
      chk("hs_not_ready", in_ready[M], 0);
      @(negedge clk);
      chk("hs_out_valid_drop", out_valid[M], 0);
      chk("hs_in_ready_rise", in_ready[M], 1);

      drain();
      send(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
      repeat (3) @(posedge clk);
      #1;
      chk("mid_run_busy", busy[M], 1);
      rst_n = 1'b0;
      #1;
      chk_reset(M, "async");
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      nv = 0;
      repeat (12) begin
         @(negedge clk);
         if (out_valid[M]) nv++;
      end
      chk("no_stale_valid", 64'(nv), 0);
      @(posedge clk);
      #1;
      send(16'd1, 16'd1, 16'd0, 16'd0);
      wait_out();
      chk("post_reset_out1", out1[M], 34'd1);
      @(posedge clk);
      #1;

      drain();
      b2b = 1'b1;
      in_valid = 1'b1;
      repeat (220) begin
         rnd();
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      b2b = 1'b0;
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
